// File: rtl/mwc_pkg.sv
// Shared types and helpers for the data-memory write checker (mem_write_checker).
package mwc_pkg;

    typedef enum logic [1:0] {
        MWC_RUN     = 2'd0,
        MWC_PASS    = 2'd1,
        MWC_FAIL    = 2'd2,
        MWC_TIMEOUT = 2'd3
    } mwc_status_e;

    localparam int unsigned MWC_MAX_W = 64;

    // Saturating increment of the low w bits; callers narrow the result back to their own width.
    function automatic logic [MWC_MAX_W-1:0] sat_inc(input logic [MWC_MAX_W-1:0] cnt,
                                                     input int unsigned w);
        logic [MWC_MAX_W-1:0] mask;
        mask = (w >= MWC_MAX_W) ? '1 : ((MWC_MAX_W'(1) << w) - MWC_MAX_W'(1));
        return ((cnt & mask) == mask) ? cnt : cnt + MWC_MAX_W'(1);
    endfunction

endpackage

// File: rtl/mwc_trace_buf.sv
// Circular log of the most recent stores; reads are relative to the oldest entry held.
module mwc_trace_buf #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [PW-1:0] rd_idx,
    output logic [W-1:0]  rd_addr,
    output logic [W-1:0]  rd_data,
    output logic [PW:0]   count
);

    logic [W-1:0]  addr_q [DEPTH];
    logic [W-1:0]  data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW:0]   count_q;
    logic [PW-1:0] oldest;
    logic [PW-1:0] rd_slot;
    logic          rd_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (wr_en) begin
            addr_q[wr_ptr_q] <= wr_addr;
            data_q[wr_ptr_q] <= wr_data;
            wr_ptr_q         <= wr_ptr_q + PW'(1);
            if (count_q != (PW+1)'(DEPTH)) begin
                count_q <= count_q + (PW+1)'(1);
            end
        end
    end

    // When full, count truncates to 0 and the oldest slot is the write pointer itself.
    assign oldest   = wr_ptr_q - count_q[PW-1:0];
    assign rd_slot  = oldest + rd_idx;
    assign rd_valid = ({1'b0, rd_idx} < count_q);
    assign rd_addr  = rd_valid ? addr_q[rd_slot] : '0;
    assign rd_data  = rd_valid ? data_q[rd_slot] : '0;
    assign count    = count_q;

endmodule

// File: rtl/mem_write_checker.sv
// End-of-test monitor on the data-memory write bus: PASS/FAIL/TIMEOUT with registered status.
// Optional store trace is built only when MWC_TRACE_EN is defined.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int unsigned      XLEN           = 32,
    parameter logic [XLEN-1:0]  TOHOST_ADDR    = XLEN'(32),
    parameter logic [XLEN-1:0]  PASS_VALUE     = XLEN'(1),
    parameter bit               STRICT         = 1'b1,
    parameter int unsigned      TIMEOUT_CYCLES = 100000,
    parameter int unsigned      CNT_W          = 32,
    parameter int unsigned      TRACE_DEPTH    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_write,
    input  logic [XLEN-1:0]              data_adr,
    input  logic [XLEN-1:0]              write_data,
    output logic [1:0]                   status,
    output logic                         done,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [CNT_W-1:0]             store_count,
    output logic [XLEN-1:0]              fail_addr,
    output logic [XLEN-1:0]              fail_data,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [XLEN-1:0]              trace_addr,
    output logic [XLEN-1:0]              trace_data,
    output logic [$clog2(TRACE_DEPTH):0] trace_count
);

    // mem_write is a one-cycle strobe with no backpressure: every sampled store is consumed.
    mwc_status_e      status_q;
    logic             done_q;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] store_count_q, store_count_d;
    logic [XLEN-1:0]  fail_addr_q, fail_data_q;
    logic             store_acc;
    logic             hit_tohost;
    logic             timeout_hit;

    assign store_acc     = (status_q == MWC_RUN) && mem_write;
    assign hit_tohost    = (data_adr == TOHOST_ADDR);
    assign timeout_hit   = (TIMEOUT_CYCLES != 0) &&
                           (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cycle_count_d = CNT_W'(sat_inc(MWC_MAX_W'(cycle_count_q), CNT_W));
    assign store_count_d = CNT_W'(sat_inc(MWC_MAX_W'(store_count_q), CNT_W));

    always_ff @(posedge clk) begin
        if (!reset) begin
            status_q      <= MWC_RUN;
            done_q        <= 1'b0;
            cycle_count_q <= '0;
            store_count_q <= '0;
            fail_addr_q   <= '0;
            fail_data_q   <= '0;
        end else begin
            case (status_q)
                MWC_RUN: begin
                    cycle_count_q <= cycle_count_d;
                    if (mem_write) begin
                        store_count_q <= store_count_d;
                    end
                    // Store decisions outrank the watchdog; a tolerated stray store does not.
                    if (mem_write && hit_tohost && (write_data == PASS_VALUE)) begin
                        status_q <= MWC_PASS;
                        done_q   <= 1'b1;
                    end else if (mem_write && (hit_tohost || STRICT)) begin
                        status_q    <= MWC_FAIL;
                        done_q      <= 1'b1;
                        fail_addr_q <= data_adr;
                        fail_data_q <= write_data;
                    end else if (timeout_hit) begin
                        status_q <= MWC_TIMEOUT;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign status      = status_q;
    assign done        = done_q;
    assign cycle_count = cycle_count_q;
    assign store_count = store_count_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;

`ifdef MWC_TRACE_EN
    mwc_trace_buf #(
        .W     (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (store_acc),
        .wr_addr (data_adr),
        .wr_data (write_data),
        .rd_idx  (trace_idx),
        .rd_addr (trace_addr),
        .rd_data (trace_data),
        .count   (trace_count)
    );
`else
    logic trace_in_unused;
    assign trace_in_unused = ^{trace_idx, store_acc};
    assign trace_addr      = '0;
    assign trace_data      = '0;
    assign trace_count     = '0;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker: three configurations share one stimulus stream.
module tb_mem_write_checker;

    localparam int NI     = 3;
    localparam int S_RUN  = 0;
    localparam int S_PASS = 1;
    localparam int S_FAIL = 2;
    localparam int S_TO   = 3;
    localparam int TDEPTH = 4;

    // Instance 0: STRICT, timeout 20. Instance 1: lenient, timeout 20. Instance 2: lenient, no watchdog, 4-bit counters.
    int     cfg_strict [NI] = '{1, 0, 0};
    int     cfg_to     [NI] = '{20, 20, 0};
    longint cfg_max    [NI] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] data_adr = '0;
    logic [31:0] write_data = '0;
    logic [1:0]  trace_idx = '0;

    logic [1:0]  st   [NI];
    logic        dn   [NI];
    logic [31:0] fa   [NI];
    logic [31:0] fd   [NI];
    logic [31:0] ta   [NI];
    logic [31:0] td   [NI];
    logic [2:0]  tcnt [NI];
    logic [31:0] cc0, cc1, sc0, sc1;
    logic [3:0]  cc2, sc2;

    always #5 clk = ~clk;

    mem_write_checker #(.STRICT(1'b1), .TIMEOUT_CYCLES(20), .TRACE_DEPTH(TDEPTH)) u_strict (
        .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
        .status(st[0]), .done(dn[0]), .cycle_count(cc0), .store_count(sc0),
        .fail_addr(fa[0]), .fail_data(fd[0]), .trace_idx(trace_idx),
        .trace_addr(ta[0]), .trace_data(td[0]), .trace_count(tcnt[0]));

    mem_write_checker #(.STRICT(1'b0), .TIMEOUT_CYCLES(20), .TRACE_DEPTH(TDEPTH)) u_loose (
        .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
        .status(st[1]), .done(dn[1]), .cycle_count(cc1), .store_count(sc1),
        .fail_addr(fa[1]), .fail_data(fd[1]), .trace_idx(trace_idx),
        .trace_addr(ta[1]), .trace_data(td[1]), .trace_count(tcnt[1]));

    mem_write_checker #(.STRICT(1'b0), .TIMEOUT_CYCLES(0), .CNT_W(4), .TRACE_DEPTH(TDEPTH)) u_small (
        .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
        .status(st[2]), .done(dn[2]), .cycle_count(cc2), .store_count(sc2),
        .fail_addr(fa[2]), .fail_data(fd[2]), .trace_idx(trace_idx),
        .trace_addr(ta[2]), .trace_data(td[2]), .trace_count(tcnt[2]));

    // ---------------- reference model ----------------
    int          m_st [NI];
    longint      m_cc [NI];
    longint      m_sc [NI];
    logic [31:0] m_fa [NI];
    logic [31:0] m_fd [NI];
    logic [63:0] tq0[$], tq1[$], tq2[$];

    function automatic void tq_push(int i, logic [63:0] e);
        case (i)
            0: begin tq0.push_back(e); if (tq0.size() > TDEPTH) void'(tq0.pop_front()); end
            1: begin tq1.push_back(e); if (tq1.size() > TDEPTH) void'(tq1.pop_front()); end
            default: begin tq2.push_back(e); if (tq2.size() > TDEPTH) void'(tq2.pop_front()); end
        endcase
    endfunction

    function automatic int tq_size(int i);
        case (i)
            0: return tq0.size();
            1: return tq1.size();
            default: return tq2.size();
        endcase
    endfunction

    function automatic logic [63:0] tq_get(int i, int idx);
        if (idx >= tq_size(i)) return 64'd0;
        case (i)
            0: return tq0[idx];
            1: return tq1[idx];
            default: return tq2[idx];
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            m_st[i] = S_RUN; m_cc[i] = 0; m_sc[i] = 0; m_fa[i] = '0; m_fd[i] = '0;
        end
        tq0.delete(); tq1.delete(); tq2.delete();
    endfunction

    function automatic void model_step(int i, logic mw, logic [31:0] a, logic [31:0] d);
        if (m_st[i] != S_RUN) return;
        if (mw) begin
            if (m_sc[i] < cfg_max[i]) m_sc[i]++;
            tq_push(i, {a, d});
            if (a == 32'd32 && d == 32'd1) begin
                m_st[i] = S_PASS;
            end else if (a == 32'd32 || cfg_strict[i] != 0) begin
                m_st[i] = S_FAIL; m_fa[i] = a; m_fd[i] = d;
            end
        end
        if (m_st[i] == S_RUN && cfg_to[i] != 0 && m_cc[i] == longint'(cfg_to[i] - 1))
            m_st[i] = S_TO;
        if (m_cc[i] < cfg_max[i]) m_cc[i]++;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]  st;
        logic        dn;
        logic [31:0] cc, sc, fa, fd, ta, td;
        logic [2:0]  tc;
    } exp_one_t;
    typedef exp_one_t [NI-1:0] exp_all_t;

    exp_all_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic void push_exp(int idx);
        exp_all_t    e;
        logic [63:0] t;
        for (int i = 0; i < NI; i++) begin
            e[i].st = 2'(m_st[i]);
            e[i].dn = (m_st[i] != S_RUN);
            e[i].cc = 32'(m_cc[i]);
            e[i].sc = 32'(m_sc[i]);
            e[i].fa = m_fa[i];
            e[i].fd = m_fd[i];
`ifdef MWC_TRACE_EN
            t = tq_get(i, idx);
            e[i].tc = 3'(tq_size(i));
`else
            t = 64'd0;
            e[i].tc = 3'd0;
`endif
            e[i].ta = t[63:32];
            e[i].td = t[31:0];
        end
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[inst%0d] at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] act_cc(int i);
        case (i)
            0: return cc0;
            1: return cc1;
            default: return {28'd0, cc2};
        endcase
    endfunction

    function automatic logic [31:0] act_sc(int i);
        case (i)
            0: return sc0;
            1: return sc1;
            default: return {28'd0, sc2};
        endcase
    endfunction

    always @(posedge clk) begin
        exp_all_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < NI; i++) begin
                chk("status",      i, {30'd0, st[i]},   {30'd0, e[i].st});
                chk("done",        i, {31'd0, dn[i]},   {31'd0, e[i].dn});
                chk("cycle_count", i, act_cc(i),        e[i].cc);
                chk("store_count", i, act_sc(i),        e[i].sc);
                chk("fail_addr",   i, fa[i],            e[i].fa);
                chk("fail_data",   i, fd[i],            e[i].fd);
                chk("trace_addr",  i, ta[i],            e[i].ta);
                chk("trace_data",  i, td[i],            e[i].td);
                chk("trace_count", i, {29'd0, tcnt[i]}, {29'd0, e[i].tc});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic reset_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            reset      = 1'b0;
            mem_write  = 1'($urandom_range(0, 1));
            data_adr   = 32'd32;
            write_data = 32'd1;
            trace_idx  = 2'($urandom_range(0, 3));
            model_reset();
            push_exp(int'(trace_idx));
        end
    endtask

    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input int idx);
        @(negedge clk);
        reset      = 1'b1;
        mem_write  = mw;
        data_adr   = a;
        write_data = d;
        trace_idx  = 2'(idx);
        for (int i = 0; i < NI; i++) model_step(i, mw, a, d);
        push_exp(idx);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, $urandom, $urandom, $urandom_range(0, 3));
    endtask

    task automatic rand_run(input int len);
        logic [31:0] a, d;
        for (int k = 0; k < len; k++) begin
            case ($urandom_range(0, 7))
                0, 1:    a = 32'd32;
                2:       a = 32'd33;
                3:       a = 32'd96;
                default: a = 32'($urandom_range(0, 63)) << 2;
            endcase
            d = ($urandom_range(0, 2) == 0) ? 32'd1 : $urandom;
            if ($urandom_range(0, 40) == 0) reset_cycles(1);
            else step($urandom_range(0, 2) == 0, a, d, $urandom_range(0, 3));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        model_reset();
        reset_cycles(2);
        idle(1);

        reset_cycles(2);
        idle(10);
        step(1'b1, 32'd32, 32'd1, 0);
        idle(3);

        reset_cycles(1);
        step(1'b1, 32'd32, 32'd0, 0);
        step(1'b1, 32'd32, 32'd1, 0);
        idle(2);

        reset_cycles(1);
        step(1'b1, 32'd96, 32'd7, 0);
        idle(2);
        step(1'b1, 32'd32, 32'd1, 1);
        idle(2);

        reset_cycles(1);
        idle(22);

        reset_cycles(1);
        idle(19);
        step(1'b1, 32'd32, 32'd1, 0);
        idle(2);

        reset_cycles(1);
        for (int k = 0; k < 6; k++) step(1'b1, 32'(4 * k), $urandom, $urandom_range(0, 3));
        step(1'b1, 32'd32, 32'd1, 0);
        for (int k = 0; k < TDEPTH; k++) step(1'b0, 32'd0, 32'd0, k);

        reset_cycles(1);
        for (int k = 0; k < 5; k++) step(1'b1, 32'd64 + 32'(k), $urandom, k % 4);
        reset_cycles(1);
        idle(2);

        reset_cycles(1);
        for (int k = 0; k < 20; k++) step(1'b1, 32'd64, $urandom, $urandom_range(0, 3));
        idle(2);

        for (int r = 0; r < 12; r++) begin
            reset_cycles(1 + $urandom_range(0, 1));
            rand_run($urandom_range(8, 30));
        end

        repeat (2) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
